// File: rtl/ddr3_init_pkg.sv
// Shared definitions for the DDR3 init sequencer: DFII register map, control/command bits,
// step-table record and FSM state encoding.
package ddr3_init_pkg;

    localparam logic [2:0] DFII_OFF_CTRL   = 3'd0;
    localparam logic [2:0] DFII_OFF_CMD    = 3'd1;
    localparam logic [2:0] DFII_OFF_STROBE = 3'd2;
    localparam logic [2:0] DFII_OFF_ADDR   = 3'd3;
    localparam logic [2:0] DFII_OFF_BADDR  = 3'd4;

    localparam logic [31:0] DFII_CTRL_SEL     = 32'h1;
    localparam logic [31:0] DFII_CTRL_CKE     = 32'h2;
    localparam logic [31:0] DFII_CTRL_ODT     = 32'h4;
    localparam logic [31:0] DFII_CTRL_RESET_N = 32'h8;

    localparam logic [31:0] DFII_CMD_CS  = 32'h1;
    localparam logic [31:0] DFII_CMD_WE  = 32'h2;
    localparam logic [31:0] DFII_CMD_CAS = 32'h4;
    localparam logic [31:0] DFII_CMD_RAS = 32'h8;

    localparam int          NUM_STEPS  = 29;
    localparam logic [29:0] RB_ADDR    = 30'h04000000;
    localparam logic [31:0] RB_PATTERN = 32'hFACECA8C;

    typedef enum logic [1:0] {
        DLY_NONE   = 2'd0,
        DLY_DLLK   = 2'd1,
        DLY_ZQINIT = 2'd2,
        DLY_SETTLE = 2'd3
    } delay_sel_t;

    typedef struct packed {
        logic [2:0]  off;
        logic [31:0] data;
        delay_sel_t  delay_sel;
    } step_t;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_RST_HOLD   = 4'd1,
        ST_RST_GAP    = 4'd2,
        ST_STEP_ISSUE = 4'd3,
        ST_STEP_ACK   = 4'd4,
        ST_STEP_GAP   = 4'd5,
        ST_DELAY      = 4'd6,
        ST_DONE       = 4'd7,
        ST_ERROR      = 4'd8
    } state_t;

    function automatic step_t make_step(input logic [2:0] s_off, input logic [31:0] s_data,
                                        input delay_sel_t s_dly);
        return '{off: s_off, data: s_data, delay_sel: s_dly};
    endfunction

endpackage

// File: rtl/ddr3_init_step_rom.sv
// Combinational step table: step index -> DFII register write (offset, data, post-step delay).
// Mode-register values come in as parameters so the top can retune them.
module ddr3_init_step_rom
    import ddr3_init_pkg::*;
#(
    parameter logic [31:0] MR0_DLLRST = 32'h320,
    parameter logic [31:0] MR1        = 32'h6,
    parameter logic [31:0] MR2        = 32'h200,
    parameter logic [31:0] MR3        = 32'h0,
    parameter logic [31:0] MR0_RUN    = 32'h220
) (
    input  logic [4:0] idx,
    output step_t      step
);

    logic [4:0]  rel;
    logic [31:0] mr_val;
    logic [31:0] mr_ba;

    always_comb begin
        step   = make_step(DFII_OFF_CTRL, 32'h0, DLY_NONE);
        rel    = idx - 5'd4;
        mr_val = 32'h0;
        mr_ba  = 32'h0;
        // Steps 4..23 are five 4-write MRS groups: MR2, MR3, MR1, MR0 (DLL reset), MR0 (run).
        case (rel[4:2])
            3'd0:    begin mr_val = MR2;        mr_ba = 32'd2; end
            3'd1:    begin mr_val = MR3;        mr_ba = 32'd3; end
            3'd2:    begin mr_val = MR1;        mr_ba = 32'd1; end
            3'd3:    begin mr_val = MR0_DLLRST; mr_ba = 32'd0; end
            default: begin mr_val = MR0_RUN;    mr_ba = 32'd0; end
        endcase

        if (idx < 5'd4) begin
            case (idx[1:0])
                2'd0:    step = make_step(DFII_OFF_ADDR,  32'h0, DLY_NONE);
                2'd1:    step = make_step(DFII_OFF_BADDR, 32'h0, DLY_NONE);
                2'd2:    step = make_step(DFII_OFF_CTRL, DFII_CTRL_ODT | DFII_CTRL_RESET_N, DLY_NONE);
                default: step = make_step(DFII_OFF_CTRL,
                                          DFII_CTRL_ODT | DFII_CTRL_RESET_N | DFII_CTRL_CKE, DLY_NONE);
            endcase
        end else if (idx < 5'd24) begin
            case (rel[1:0])
                2'd0:    step = make_step(DFII_OFF_ADDR,  mr_val, DLY_NONE);
                2'd1:    step = make_step(DFII_OFF_BADDR, mr_ba,  DLY_NONE);
                2'd2:    step = make_step(DFII_OFF_CMD,
                                          DFII_CMD_RAS | DFII_CMD_CAS | DFII_CMD_WE | DFII_CMD_CS,
                                          DLY_NONE);
                default: step = make_step(DFII_OFF_STROBE, 32'h1,
                                          (idx == 5'd23) ? DLY_DLLK : DLY_NONE);
            endcase
        end else begin
            case (idx)
                5'd24:   step = make_step(DFII_OFF_ADDR,   32'h400, DLY_NONE);
                5'd25:   step = make_step(DFII_OFF_BADDR,  32'h0,   DLY_NONE);
                5'd26:   step = make_step(DFII_OFF_CMD,    DFII_CMD_WE | DFII_CMD_CS, DLY_NONE);
                5'd27:   step = make_step(DFII_OFF_STROBE, 32'h1,   DLY_ZQINIT);
                5'd28:   step = make_step(DFII_OFF_CTRL,   DFII_CTRL_SEL, DLY_SETTLE);
                default: step = make_step(DFII_OFF_CTRL,   32'h0,   DLY_NONE);
            endcase
        end
    end

endmodule

// File: rtl/ddr3_init_sequencer.sv
// DDR3 bring-up sequencer: Wishbone master walking the DFII init table, then handing over to hardware.
// Optional DDR3_INIT_READBACK_EN adds a write/readback sanity check of one DRAM word before done.
module ddr3_init_sequencer
    import ddr3_init_pkg::*;
#(
    parameter logic [29:0] DFII_BASE    = 30'h2400,
    parameter int          T_RESET_CYC  = 35,
    parameter int          T_DLLK_CYC   = 600,
    parameter int          T_ZQINIT_CYC = 600,
    parameter int          T_SETTLE_CYC = 200,
    parameter int          ACK_TIMEOUT  = 255,
    parameter logic [31:0] MR0_DLLRST   = 32'h320,
    parameter logic [31:0] MR1          = 32'h6,
    parameter logic [31:0] MR2          = 32'h200,
    parameter logic [31:0] MR3          = 32'h0,
    parameter logic [31:0] MR0_RUN      = 32'h220
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        dram_rst,
    output logic [29:0] wb_adr,
    output logic [31:0] wb_dat_w,
    input  logic [31:0] wb_dat_r,
    output logic [3:0]  wb_sel,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    input  logic        wb_ack,
    output state_t      dbg_state
);

    // Bus handshake: a transaction is live while cyc=stb=1 and completes on the cycle wb_ack is
    // sampled high; address/data/we/sel stay constant until then, and cyc/stb fall the next cycle.
    localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT - 1);
`ifdef DDR3_INIT_READBACK_EN
    localparam logic [4:0] RB_WR_IDX = 5'd29;
    localparam logic [4:0] RB_RD_IDX = 5'd30;
    localparam logic [4:0] LAST_IDX  = 5'd30;
`else
    localparam logic [4:0] LAST_IDX  = 5'd28;
`endif

    state_t      state, state_nxt, ack_state;
    logic [4:0]  step_idx, idx_nxt;
    logic [15:0] cnt, cnt_nxt, dly_len;
    logic [7:0]  ack_timer, timer_nxt;
    logic        dram_rst_nxt, advance, bus_active;
    step_t       step;

    ddr3_init_step_rom #(
        .MR0_DLLRST (MR0_DLLRST),
        .MR1        (MR1),
        .MR2        (MR2),
        .MR3        (MR3),
        .MR0_RUN    (MR0_RUN)
    ) u_rom (
        .idx  (step_idx),
        .step (step)
    );

    always_comb begin
        dly_len = 16'd0;
        case (step.delay_sel)
            DLY_DLLK:   dly_len = 16'(T_DLLK_CYC);
            DLY_ZQINIT: dly_len = 16'(T_ZQINIT_CYC);
            DLY_SETTLE: dly_len = 16'(T_SETTLE_CYC);
            default:    dly_len = 16'd0;
        endcase
    end

`ifdef DDR3_INIT_READBACK_EN
    assign ack_state = (step_idx == RB_RD_IDX && wb_dat_r != RB_PATTERN) ? ST_ERROR : ST_STEP_GAP;
`else
    logic unused_dat_r;
    assign unused_dat_r = ^wb_dat_r;
    assign ack_state    = ST_STEP_GAP;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            step_idx  <= 5'd0;
            cnt       <= 16'd0;
            ack_timer <= 8'd0;
            dram_rst  <= 1'b1;
        end else begin
            state     <= state_nxt;
            step_idx  <= idx_nxt;
            cnt       <= cnt_nxt;
            ack_timer <= timer_nxt;
            dram_rst  <= dram_rst_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = step_idx;
        cnt_nxt      = cnt;
        timer_nxt    = 8'd0;
        dram_rst_nxt = dram_rst;
        advance      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_nxt    = ST_RST_HOLD;
                    cnt_nxt      = 16'd0;
                    idx_nxt      = 5'd0;
                    dram_rst_nxt = 1'b1;
                end
            end
            ST_RST_HOLD: begin
                if (17'(cnt) + 17'd1 >= 17'(T_RESET_CYC)) begin
                    dram_rst_nxt = 1'b0;
                    state_nxt    = ST_RST_GAP;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_RST_GAP: begin
                idx_nxt   = 5'd0;
                state_nxt = ST_STEP_ISSUE;
            end
            // The issue cycle already counts toward the ack timeout and accepts a same-cycle ack.
            ST_STEP_ISSUE: begin
                timer_nxt = ack_timer + 8'd1;
                state_nxt = wb_ack ? ack_state : ST_STEP_ACK;
            end
            ST_STEP_ACK: begin
                if (wb_ack)                      state_nxt = ack_state;
                else if (ack_timer == ACK_LIMIT) state_nxt = ST_ERROR;
                else                             timer_nxt = ack_timer + 8'd1;
            end
            ST_STEP_GAP: begin
                if (dly_len != 16'd0) begin
                    cnt_nxt   = 16'd0;
                    state_nxt = ST_DELAY;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_DELAY: begin
                if (17'(cnt) + 17'd1 >= 17'(dly_len)) advance = 1'b1;
                else                                  cnt_nxt = cnt + 16'd1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (advance) begin
            if (step_idx == LAST_IDX) begin
                state_nxt = ST_DONE;
            end else begin
                idx_nxt   = step_idx + 5'd1;
                state_nxt = ST_STEP_ISSUE;
            end
        end
    end

    assign bus_active = (state == ST_STEP_ISSUE) || (state == ST_STEP_ACK);

    always_comb begin
        wb_adr   = 30'd0;
        wb_dat_w = 32'd0;
        wb_we    = 1'b0;
        if (bus_active) begin
            if (step_idx < 5'(NUM_STEPS)) begin
                wb_adr   = DFII_BASE + {27'd0, step.off};
                wb_dat_w = step.data;
                wb_we    = 1'b1;
`ifdef DDR3_INIT_READBACK_EN
            end else if (step_idx == RB_WR_IDX) begin
                wb_adr   = RB_ADDR;
                wb_dat_w = RB_PATTERN;
                wb_we    = 1'b1;
            end else begin
                wb_adr   = RB_ADDR;
`endif
            end
        end
    end

    assign wb_cyc    = bus_active;
    assign wb_stb    = bus_active;
    assign wb_sel    = bus_active ? 4'hF : 4'h0;
    assign busy      = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERROR);
    assign dbg_state = state;

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Bench for ddr3_init_sequencer: Wishbone slave model acking after 2 cycles, expected-write
// scoreboard, timing checks on reset hold, inter-transaction gaps, delays and ack timeout.
`timescale 1ns/1ps
module tb_ddr3_init_sequencer;
    import ddr3_init_pkg::*;

    localparam int W         = 68;
    localparam int T_RESET   = 35;
    localparam int T_DLLK    = 600;
    localparam int T_ZQINIT  = 600;
    localparam int T_SETTLE  = 200;
`ifdef DDR3_INIT_READBACK_EN
    localparam int NTOT = NUM_STEPS + 2;
`else
    localparam int NTOT = NUM_STEPS;
`endif

    localparam logic [2:0] EXP_OFF [NUM_STEPS] = '{
        3'd3, 3'd4, 3'd0, 3'd0,
        3'd3, 3'd4, 3'd1, 3'd2,  3'd3, 3'd4, 3'd1, 3'd2,  3'd3, 3'd4, 3'd1, 3'd2,
        3'd3, 3'd4, 3'd1, 3'd2,  3'd3, 3'd4, 3'd1, 3'd2,
        3'd3, 3'd4, 3'd1, 3'd2,  3'd0};
    localparam logic [31:0] EXP_DAT [NUM_STEPS] = '{
        32'h0, 32'h0, 32'h0C, 32'h0E,
        32'h200, 32'h2, 32'h0F, 32'h1,  32'h0, 32'h3, 32'h0F, 32'h1,
        32'h6, 32'h1, 32'h0F, 32'h1,    32'h320, 32'h0, 32'h0F, 32'h1,
        32'h220, 32'h0, 32'h0F, 32'h1,  32'h400, 32'h0, 32'h03, 32'h1,  32'h1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, error, dram_rst;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r = 32'h0;
    logic [3:0]  wb_sel;
    logic        wb_cyc, wb_stb, wb_we;
    logic        wb_ack = 1'b0;
    state_t      dbg_state;

    int          checks = 0;
    int          failures = 0;
    logic [W-1:0] exp_q[$];
    int          txn_count = 0;
    int          stall_step = -1;
    int          idle_run = 0;
    int          stuck_cyc = 0;
    logic        prev_cyc = 1'b0;
    logic        prev_done = 1'b0;
    logic        rd_zero = 1'b0;
    logic [1:0]  wait_cnt = 2'd0;
    logic [31:0] rb_word = 32'h0;

    // clock / reset
    always #5 clk = ~clk;

    ddr3_init_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .dram_rst  (dram_rst),
        .wb_adr    (wb_adr),
        .wb_dat_w  (wb_dat_w),
        .wb_dat_r  (wb_dat_r),
        .wb_sel    (wb_sel),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_ack    (wb_ack),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] bus_rec(input logic we, input logic [29:0] adr,
                                             input logic [31:0] dat);
        return {we, adr, dat, 4'hF, 1'b1};
    endfunction

    function automatic int exp_gap(input int prev_idx);
        if (prev_idx == 23) return T_DLLK + 1;
        if (prev_idx == 27) return T_ZQINIT + 1;
        return 1;
    endfunction

    // driver tasks
    task automatic push_run(input int n);
        for (int i = 0; i < n; i++) begin
            if (i < NUM_STEPS)
                exp_q.push_back(bus_rec(1'b1, 30'h2400 + {27'd0, EXP_OFF[i]}, EXP_DAT[i]));
`ifdef DDR3_INIT_READBACK_EN
            else if (i == NUM_STEPS)
                exp_q.push_back(bus_rec(1'b1, RB_ADDR, RB_PATTERN));
            else
                exp_q.push_back(bus_rec(1'b0, RB_ADDR, 32'h0));
`endif
        end
    endtask

    task automatic start_run(input int n);
        @(negedge clk);
        txn_count = 0;
        stuck_cyc = 0;
        push_run(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_high(input string tag, input bit want_done, input int budget);
        int n = 0;
        while ((want_done ? done : error) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, W'(want_done ? done : error), W'(1));
    endtask

    // Wishbone slave: ack in the third cycle of a transaction unless this step is stalled.
    always @(posedge clk) begin
        if (wb_cyc && wb_stb && wb_ack && wb_we && wb_adr == RB_ADDR) rb_word <= wb_dat_w;
        if (wb_cyc && wb_stb && !wb_ack) begin
            if (wait_cnt == 2'd1) begin
                if (txn_count != stall_step) begin
                    wb_ack   <= 1'b1;
                    wait_cnt <= 2'd0;
                    wb_dat_r <= rd_zero ? 32'h0 : rb_word;
                end
            end else begin
                wait_cnt <= wait_cnt + 2'd1;
            end
        end else begin
            wb_ack   <= 1'b0;
            wait_cnt <= 2'd0;
        end
    end

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
`ifndef DDR3_INIT_READBACK_EN
        if (done && !prev_done && txn_count == NTOT)
            check("settle_gap", W'(idle_run), W'(T_SETTLE + 1));
`endif
        if (wb_cyc && !prev_cyc && txn_count > 0 && txn_count != NUM_STEPS)
            check($sformatf("gap_before_%0d", txn_count), W'(idle_run), W'(exp_gap(txn_count - 1)));
        if (stall_step >= 0 && wb_cyc && txn_count == stall_step) stuck_cyc++;
        if (wb_cyc && wb_stb && wb_ack) begin
            check("q_nonempty", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0)
                check($sformatf("txn%0d", txn_count), {wb_we, wb_adr, wb_dat_w, wb_sel, wb_stb},
                      exp_q.pop_front());
            txn_count++;
        end
        idle_run  = wb_cyc ? 0 : idle_run + 1;
        prev_cyc  = wb_cyc;
        prev_done = done;
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_error", W'(error), W'(0));
        check("rst_dram_rst", W'(dram_rst), W'(1));
        check("rst_bus", {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w}, W'(0));
        rst = 1'b0;

        // full run, reset-hold length
        start_run(NTOT);
        check("busy_after_start", W'(busy), W'(1));
        n = 0;
        while (dram_rst && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("dram_rst_hold", W'(n), W'(T_RESET));
        wait_high("done_run1", 1'b1, 4000);
        check("run1_busy", W'(busy), W'(0));
        check("run1_error", W'(error), W'(0));
        check("run1_count", W'(txn_count), W'(NTOT));
        check("run1_dram_rst", W'(dram_rst), W'(0));

        // restart from DONE, with a stray start while busy
        start_run(NTOT);
        check("rerun_done_drop", W'(done), W'(0));
        check("rerun_dram_rst", W'(dram_rst), W'(1));
        repeat (150) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignored_start", W'(busy), W'(1));
        wait_high("done_run2", 1'b1, 4000);
        check("run2_count", W'(txn_count), W'(NTOT));
        check("run2_q_empty", W'(exp_q.size()), W'(0));

        // ack timeout on step 6
        stall_step = 6;
        start_run(6);
        wait_high("timeout_error", 1'b0, 3000);
        check("timeout_stuck_cycles", W'(stuck_cyc), W'(255));
        check("timeout_flags", {busy, done, wb_cyc, wb_stb}, W'(0));
        check("timeout_q_empty", W'(exp_q.size()), W'(0));
        stall_step = -1;

        // async reset during step 10 ack wait, then fresh run
        start_run(10);
        check("start_clears_error", W'(error), W'(0));
        n = 0;
        while (!(txn_count == 10 && wb_cyc) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_step10", W'(txn_count == 10 && wb_cyc), W'(1));
        @(negedge clk);
        check("step10_in_ack", W'(dbg_state), W'(ST_STEP_ACK));
        rst = 1'b1;
        #1;
        check("rst_mid_bus", {wb_cyc, wb_stb, busy}, W'(0));
        check("rst_mid_dram_rst", W'(dram_rst), W'(1));
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_q_empty", W'(exp_q.size()), W'(0));
        start_run(NTOT);
        wait_high("done_after_rst", 1'b1, 4000);
        check("run3_count", W'(txn_count), W'(NTOT));

`ifdef DDR3_INIT_READBACK_EN
        rd_zero = 1'b1;
        start_run(NTOT);
        wait_high("readback_mismatch", 1'b0, 4000);
        check("readback_done", W'(done), W'(0));
        rd_zero = 1'b0;
`endif

        check("final_q_empty", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
